// File: rtl/tinyqv_mem_arbiter.sv
// rtl/tinyqv_mem_arbiter.sv - shares a byte-serial memory backend between instruction streaming and data accesses
module tinyqv_mem_arbiter #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ADDR_BITS-1:1] instr_addr,
  input  logic                 instr_fetch_restart,
  input  logic                 instr_fetch_stall,
  output logic                 instr_fetch_started,
  output logic                 instr_fetch_stopped,
  output logic [7:0]           instr_data_in,
  output logic                 instr_ready,
  input  logic [ADDR_BITS-1:0] data_addr,
  input  logic [1:0]           data_write_n,
  input  logic [1:0]           data_read_n,
  input  logic [31:0]          data_out,
  output logic                 data_ready,
  output logic [31:0]          data_in,
  output logic                 mem_start,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_write,
  output logic [2:0]           mem_len,
  output logic                 mem_stop,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_byte_ready,
  input  logic                 mem_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_STOPPING,
    S_DATA,
    S_DATA_ACK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic                 mem_start_q, mem_start_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_write_q, mem_write_d;
  logic [2:0]           mem_len_q, mem_len_d;
  logic                 mem_stop_q, mem_stop_d;
  logic                 started_q, started_d;
  logic                 stopped_q, stopped_d;
  logic                 data_ready_q, data_ready_d;
  logic [31:0]          data_in_q, data_in_d;

  logic       data_req;
  logic       data_wr;
  logic [1:0] data_code;
  logic [2:0] req_len;
  logic       last_byte;
  logic       stream_stop;

  always_comb begin
    data_req  = (data_write_n != 2'b11) || (data_read_n != 2'b11);
    data_wr   = (data_write_n != 2'b11);
    data_code = data_wr ? data_write_n : data_read_n;
    case (data_code)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
    last_byte = ({1'b0, idx_q} == (mem_len_q - 3'd1));
    // started_q marks the first INSTR cycle, where restart is still legitimately high
    stream_stop = data_req || instr_fetch_stall || (instr_fetch_restart && !started_q);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mem_start_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_write_d  = mem_write_q;
    mem_len_d    = mem_len_q;
    mem_stop_d   = 1'b0;
    started_d    = 1'b0;
    stopped_d    = 1'b0;
    data_ready_d = 1'b0;
    data_in_d    = data_in_q;
    case (state_q)
      S_IDLE: begin
        if (!mem_busy) begin
          if (data_req) begin
            mem_start_d = 1'b1;
            mem_addr_d  = data_addr;
            mem_write_d = data_wr;
            mem_len_d   = req_len;
            idx_d       = 2'd0;
            data_in_d   = 32'h0;
            state_d     = S_DATA;
          end else if (instr_fetch_restart && !instr_fetch_stall) begin
            mem_start_d = 1'b1;
            mem_addr_d  = {instr_addr, 1'b0};
            mem_write_d = 1'b0;
            mem_len_d   = 3'd0;
            started_d   = 1'b1;
            state_d     = S_INSTR;
          end
        end
      end
      S_INSTR: begin
        if (stream_stop) begin
          mem_stop_d = 1'b1;
          state_d    = S_STOPPING;
        end
      end
      S_STOPPING: begin
        // busy is only trusted once the backend has seen the stop pulse
        if (!mem_busy && !mem_stop_q) begin
          stopped_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DATA: begin
        if (mem_byte_ready) begin
          if (!mem_write_q) begin
            data_in_d[{idx_q, 3'b000} +: 8] = mem_rdata;
          end
          idx_d = idx_q + 2'd1;
          if (last_byte) begin
            data_ready_d = 1'b1;
            state_d      = S_DATA_ACK;
          end
        end
      end
      S_DATA_ACK: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      mem_start_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_len_q    <= 3'd0;
      mem_stop_q   <= 1'b0;
      started_q    <= 1'b0;
      stopped_q    <= 1'b0;
      data_ready_q <= 1'b0;
      data_in_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mem_start_q  <= mem_start_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_len_q    <= mem_len_d;
      mem_stop_q   <= mem_stop_d;
      started_q    <= started_d;
      stopped_q    <= stopped_d;
      data_ready_q <= data_ready_d;
      data_in_q    <= data_in_d;
    end
  end

  assign mem_start           = mem_start_q;
  assign mem_addr            = mem_addr_q;
  assign mem_write           = mem_write_q;
  assign mem_len             = mem_len_q;
  assign mem_stop            = mem_stop_q;
  assign mem_wdata           = data_out[{idx_q, 3'b000} +: 8];
  assign instr_fetch_started = started_q;
  assign instr_fetch_stopped = stopped_q;
  assign data_ready          = data_ready_q;
  assign data_in             = data_in_q;
  assign instr_data_in       = (state_q == S_INSTR) ? mem_rdata : 8'h00;
  assign instr_ready         = (state_q == S_INSTR) && mem_byte_ready && !instr_fetch_stall &&
                               !started_q && !instr_fetch_restart;

endmodule

// File: doc/tinyqv_mem_arbiter.md
Name: tinyqv_mem_arbiter

Overview:
- Shares one byte-serial memory backend (QSPI flash/PSRAM controller) between the CPU instruction-fetch stream and CPU data load/store requests.
- Sits between tinyqv_cpu and the memory backend.
- Starts, stops and restarts instruction streams. Data accesses take priority and pre-empt streaming.
- Assembles/disassembles 8/16/32-bit data words little-endian.

Parameters:
- ADDR_BITS, 24, byte address width presented to the backend.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- instr_addr  in  ADDR_BITS-1  halfword address for the next fetch stream ([ADDR_BITS-1:1]).
- instr_fetch_restart  in  1  high = CPU has no running stream and wants one.
- instr_fetch_stall  in  1  high = CPU buffer full; stop streaming.
- instr_fetch_started  out  1  1-cycle pulse: stream started.
- instr_fetch_stopped  out  1  1-cycle pulse: stream ended.
- instr_data_in  out  8  fetched byte.
- instr_ready  out  1  instr_data_in valid this cycle.
- data_addr  in  ADDR_BITS  data byte address.
- data_write_n  in  2  11 none, 00 byte, 01 half, 10 word.
- data_read_n  in  2  same encoding.
- data_out  in  32  store data.
- data_ready  out  1  1-cycle completion pulse.
- data_in  out  32  load data, zero-extended.
- mem_start  out  1  start transaction (honoured when mem_busy=0).
- mem_addr  out  ADDR_BITS  start address, held while busy.
- mem_write  out  1  1 = write.
- mem_len  out  3  bytes 1/2/4; 0 = unbounded stream.
- mem_stop  out  1  1-cycle pulse: terminate stream.
- mem_wdata  out  8  current write byte.
- mem_rdata  in  8  read byte.
- mem_byte_ready  in  1  1 byte transferred this cycle.
- mem_busy  in  1  backend transaction active.

Behaviour:
- Reset values:
  - All pulse outputs 0.
  - mem_start 0, mem_write 0, mem_len 0.
  - data_in 0, instr_data_in 0.
  - State IDLE, byte index 0.
- States: IDLE, INSTR, STOPPING, DATA, DATA_ACK.
- IDLE (requires mem_busy=0):
  - If data_write_n!=11 or data_read_n!=11: mem_start=1, mem_addr=data_addr, mem_write=(write), mem_len from code (00→1, 01→2, 10→4). Next state DATA.
  - Else if instr_fetch_restart=1 and instr_fetch_stall=0: mem_start=1, mem_addr={instr_addr,0}, mem_len=0, mem_write=0, instr_fetch_started=1. Next state INSTR.
  - Data wins when both requests are present.
  - Write and read both requested = write.
- INSTR:
  - Each mem_byte_ready: instr_data_in=mem_rdata and instr_ready=1, only when instr_fetch_stall=0 and not the first INSTR cycle or a later cycle with restart=1. Otherwise the byte is dropped; the CPU refetches from its recomputed address.
  - Stop conditions:
    - Data request pending.
    - instr_fetch_stall=1.
    - instr_fetch_restart=1 on any cycle except the first INSTR cycle. This is a branch: the CPU drops its running flag one cycle after started.
  - On any stop condition: mem_stop=1 for 1 cycle, then STOPPING.
- STOPPING:
  - Bytes are discarded.
  - When mem_busy=0: instr_fetch_stopped=1 for 1 cycle, then IDLE.
- DATA:
  - Byte index i runs 0..len-1. Write: mem_wdata=data_out[8i+:8]. Read: byte stored to data_in[8i+:8].
  - data_in bits above len are cleared at start.
  - i increments on mem_byte_ready.
  - On the last byte: DATA_ACK.
- DATA_ACK:
  - data_ready=1 with data_in stable for exactly 1 cycle.
  - The request inputs are ignored this cycle (CPU clears them on this edge).
  - Then IDLE. IDLE waits for mem_busy=0 before any new mem_start.
- Latency:
  - Data: data_ready comes 1 cycle after the final mem_byte_ready.
  - Fetch: instr_ready is the same cycle as mem_byte_ready (combinational pass-through of mem_rdata, gated by state).
- mem_start is a 1-cycle pulse, asserted only when mem_busy=0.
- mem_addr, mem_len and mem_write are held until the next start.
- Data request arriving in the same cycle as a stream stop condition: single mem_stop, single stopped pulse, then data first.
- Reset mid-transaction: returns to IDLE immediately, no stopped pulse. The backend shares rstn.
- No started/stopped pulse is ever issued for data transactions.

Test Plan:
- Fetch only: restart=1, instr_addr=0x000100 → mem_start, mem_addr=0x000200, mem_len=0, started pulse. 6 bytes 0x13,0x05,... forwarded as instr_ready in order.
- Stall: stall rises after 4 bytes → mem_stop 1 cycle; 5th byte dropped; stopped pulse after mem_busy falls. Stall falls with restart=1 → new stream at new instr_addr.
- Load pre-empts fetch: streaming, data_read_n=10, data_addr=0x001004 → mem_stop, stopped, then read len 4. Bytes 0x78,0x56,0x34,0x12 → data_in=0x12345678, data_ready 1 cycle after last byte. Then fetch restarts.
- Byte/half store: data_write_n=01, data_out=0xAABBCCDD → mem_write=1, mem_len=2, mem_wdata 0xDD then 0xCC, one data_ready pulse. Byte load of 0x80 → data_in=0x00000080.
- Branch mid-stream: restart goes high in INSTR cycle 3 → mem_stop. Bytes during STOPPING not forwarded. Stopped pulse; restart from new instr_addr.
- Reset asserted during DATA read with 2 of 4 bytes done → all outputs at reset values next cycle. No data_ready issued.
